// File: rtl/tusca_config_rx.sv
// Configuration frame receiver: waits for A5,MSB,LSB,CHK from the UART and updates the measurement interval.
// Latency: checksum byte at t -> VALIDA at t+1, pronto_config/erro_config pulse at t+2, idle at t+3.
// Backpressure: none; one rx_pronto per cycle is consumed. TUSCA_CONFIG_RANGE_CHECK_EN enables the MIN/MAX range check.
module tusca_config_rx #(
  parameter int unsigned TIMEOUT_CYCLES   = 50_000_000,
  parameter logic [15:0] DEFAULT_INTERVAL = 16'd60,
  parameter logic [15:0] MIN_INTERVAL     = 16'd2,
  parameter logic [15:0] MAX_INTERVAL     = 16'd3600
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        receber_config,
  input  logic        cancelar,
  input  logic [7:0]  rx_dado,
  input  logic        rx_pronto,
  output logic [15:0] intervalo,
  output logic        pronto_config,
  output logic        erro_config,
  output logic        ocupado,
  output logic [3:0]  db_estado
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  // The counter equals this value on the last cycle before the timeout edge.
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] CABECALHO = 8'hA5;

  typedef enum logic [3:0] {
    OCIOSO           = 4'd0,
    ESPERA_CABECALHO = 4'd1,
    ESPERA_MSB       = 4'd2,
    ESPERA_LSB       = 4'd3,
    ESPERA_CHECKSUM  = 4'd4,
    VALIDA           = 4'd5,
    APLICA           = 4'd6,
    ERRO             = 4'd7
  } estado_t;

  estado_t       estado, estado_prox;
  logic [CW-1:0] cnt_timeout;
  logic [7:0]    byte_msb, byte_lsb, byte_chk;
  logic          espera, timeout, aceita;
  logic          soma_ok, faixa_ok, quadro_ok;
  logic [15:0]   valor;

  assign valor   = {byte_msb, byte_lsb};
  assign soma_ok = (byte_chk == (CABECALHO ^ byte_msb ^ byte_lsb));

`ifdef TUSCA_CONFIG_RANGE_CHECK_EN
  assign faixa_ok = (valor >= MIN_INTERVAL) && (valor <= MAX_INTERVAL);
`else
  assign faixa_ok = (valor != 16'd0);
  logic unused_faixa;
  assign unused_faixa = ^{MIN_INTERVAL, MAX_INTERVAL};
`endif

  assign quadro_ok = soma_ok && faixa_ok;
  assign espera    = (estado == ESPERA_CABECALHO) || (estado == ESPERA_MSB) ||
                     (estado == ESPERA_LSB) || (estado == ESPERA_CHECKSUM);
  assign timeout   = espera && (cnt_timeout == TO_LAST);

  always_ff @(posedge clock) begin
    if (reset) estado <= OCIOSO;
    else       estado <= estado_prox;
  end

  // cancelar beats timeout, which beats a byte arriving in the same cycle.
  always_comb begin
    estado_prox = estado;
    aceita      = 1'b0;
    case (estado)
      OCIOSO: if (receber_config) estado_prox = ESPERA_CABECALHO;
      ESPERA_CABECALHO, ESPERA_MSB, ESPERA_LSB, ESPERA_CHECKSUM: begin
        if (cancelar) begin
          estado_prox = OCIOSO;
        end else if (timeout) begin
          estado_prox = ERRO;
        end else if (rx_pronto) begin
          case (estado)
            ESPERA_CABECALHO: if (rx_dado == CABECALHO) begin
              aceita      = 1'b1;
              estado_prox = ESPERA_MSB;
            end
            ESPERA_MSB: begin
              aceita      = 1'b1;
              estado_prox = ESPERA_LSB;
            end
            ESPERA_LSB: begin
              aceita      = 1'b1;
              estado_prox = ESPERA_CHECKSUM;
            end
            default: begin
              aceita      = 1'b1;
              estado_prox = VALIDA;
            end
          endcase
        end
      end
      VALIDA:       estado_prox = quadro_ok ? APLICA : ERRO;
      APLICA, ERRO: estado_prox = OCIOSO;
      default:      estado_prox = OCIOSO;
    endcase
  end

  // Discarded noise bytes keep counting; only accepted bytes restart the window.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_timeout <= '0;
    end else if (espera && !aceita) begin
      cnt_timeout <= cnt_timeout + CW'(1);
    end else begin
      cnt_timeout <= '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      byte_msb <= 8'h00;
      byte_lsb <= 8'h00;
      byte_chk <= 8'h00;
    end else if (aceita) begin
      if (estado == ESPERA_MSB)      byte_msb <= rx_dado;
      if (estado == ESPERA_LSB)      byte_lsb <= rx_dado;
      if (estado == ESPERA_CHECKSUM) byte_chk <= rx_dado;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      intervalo <= DEFAULT_INTERVAL;
    end else if (estado == VALIDA && quadro_ok) begin
      intervalo <= valor;
    end
  end

  assign pronto_config = (estado == APLICA);
  assign erro_config   = (estado == ERRO);
  assign ocupado       = (estado != OCIOSO);
  assign db_estado     = estado;

endmodule

// File: tb/tb_tusca_config_rx.sv
// Bench for tusca_config_rx: fixed frame table, corner-case sequences and random frames against a frame-level model.
module tb_tusca_config_rx;

  localparam int TO = 100;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        receber_config = 1'b0;
  logic        cancelar = 1'b0;
  logic [7:0]  rx_dado = 8'h00;
  logic        rx_pronto = 1'b0;
  logic [15:0] intervalo;
  logic        pronto_config, erro_config, ocupado;
  logic [3:0]  db_estado;

  tusca_config_rx #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .receber_config(receber_config), .cancelar(cancelar),
    .rx_dado(rx_dado), .rx_pronto(rx_pronto), .intervalo(intervalo),
    .pronto_config(pronto_config), .erro_config(erro_config), .ocupado(ocupado),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  logic [15:0] model_int;

  typedef struct packed {
    logic [7:0]  b0, b1, b2, b3;
    logic        ok;
    logic [15:0] exp_int;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_dado   = b;
    rx_pronto = 1'b1;
    tick();
    rx_pronto = 1'b0;
  endtask

  task automatic start();
    receber_config = 1'b1;
    tick();
    receber_config = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Called right after the checksum byte has been clocked in.
  task automatic finish_frame(input string tag, input bit ok, input logic [15:0] exp_int);
    chk({tag, " valida"}, db_estado, 5);
    chk({tag, " valida_pulses"}, {pronto_config, erro_config}, 0);
    tick();
    chk({tag, " pronto"}, pronto_config, ok);
    chk({tag, " erro"}, erro_config, !ok);
    chk({tag, " intervalo"}, intervalo, exp_int);
    tick();
    chk({tag, " idle_state"}, db_estado, 0);
    chk({tag, " idle_ocupado"}, ocupado, 0);
    chk({tag, " idle_pulses"}, {pronto_config, erro_config}, 0);
  endtask

  function automatic bit ref_ok(input logic [7:0] m, input logic [7:0] l, input logic [7:0] c);
    int v;
    v = {m, l};
    if (c != (8'hA5 ^ m ^ l)) return 1'b0;
`ifdef TUSCA_CONFIG_RANGE_CHECK_EN
    return (v >= 2) && (v <= 3600);
`else
    return v != 0;
`endif
  endfunction

  initial begin
    int n;
    int pulses;
    logic [7:0]  m, l, c, nb;
    logic [15:0] v;
    bit ok;

`ifdef TUSCA_CONFIG_RANGE_CHECK_EN
    tbl[0] = '{8'hA5, 8'h00, 8'h0A, 8'h00, 1'b0, 16'd60};
    tbl[1] = '{8'hA5, 8'h00, 8'h0A, 8'hAF, 1'b1, 16'd10};
    tbl[2] = '{8'hA5, 8'h00, 8'h01, 8'hA4, 1'b0, 16'd10};
    tbl[3] = '{8'hA5, 8'h0E, 8'h11, 8'hBA, 1'b0, 16'd10};
    tbl[4] = '{8'hA5, 8'h00, 8'h00, 8'hA5, 1'b0, 16'd10};
`else
    tbl[0] = '{8'hA5, 8'h00, 8'h0A, 8'h00, 1'b0, 16'd60};
    tbl[1] = '{8'hA5, 8'h00, 8'h0A, 8'hAF, 1'b1, 16'd10};
    tbl[2] = '{8'hA5, 8'h00, 8'h01, 8'hA4, 1'b1, 16'd1};
    tbl[3] = '{8'hA5, 8'h0E, 8'h11, 8'hBA, 1'b1, 16'd3601};
    tbl[4] = '{8'hA5, 8'h00, 8'h00, 8'hA5, 1'b0, 16'd3601};
`endif
    tbl[5] = '{8'hA5, 8'h0E, 8'h10, 8'hBB, 1'b1, 16'd3600};
    tbl[6] = '{8'hA5, 8'h00, 8'h02, 8'hA7, 1'b1, 16'd2};

    idle(3);
    reset = 1'b0;
    chk("rst state", db_estado, 0);
    chk("rst intervalo", intervalo, 60);
    chk("rst pronto", pronto_config, 0);
    chk("rst erro", erro_config, 0);
    chk("rst ocupado", ocupado, 0);

    send(8'hA5);
    chk("idle_rx state", db_estado, 0);
    chk("idle_rx ocupado", ocupado, 0);

    for (int i = 0; i < 7; i++) begin
      start();
      chk($sformatf("tbl%0d start_state", i), db_estado, 1);
      chk($sformatf("tbl%0d start_ocupado", i), ocupado, 1);
      send(tbl[i].b0);
      send(tbl[i].b1);
      send(tbl[i].b2);
      send(tbl[i].b3);
      finish_frame($sformatf("tbl%0d", i), tbl[i].ok, tbl[i].exp_int);
    end
    model_int = tbl[6].exp_int;

    // Second request mid-frame is ignored; frame still completes.
    start();
    send(8'hA5);
    receber_config = 1'b1;
    tick();
    receber_config = 1'b0;
    chk("rereq state", db_estado, 2);
    send(8'h00);
    send(8'h0A);
    send(8'hAF);
    model_int = 16'd10;
    finish_frame("rereq", 1'b1, model_int);

    // Noise bytes, partial frame, then silence until timeout.
    start();
    send(8'h3C);
    chk("noise state1", db_estado, 1);
    send(8'hFF);
    chk("noise state2", db_estado, 1);
    send(8'hA5);
    send(8'h00);
    chk("timeout pre_state", db_estado, 3);
    n = 0;
    while (!erro_config && n < 300) begin
      tick();
      n++;
    end
    chk("timeout latency", n, TO);
    chk("timeout state", db_estado, 7);
    chk("timeout intervalo", intervalo, model_int);
    tick();
    chk("timeout idle", db_estado, 0);

    // Cancel collides with a data byte.
    start();
    send(8'hA5);
    send(8'h00);
    rx_dado   = 8'h0A;
    rx_pronto = 1'b1;
    cancelar  = 1'b1;
    tick();
    rx_pronto = 1'b0;
    cancelar  = 1'b0;
    chk("cancel state", db_estado, 0);
    pulses = pronto_config + erro_config;
    for (int k = 0; k < 5; k++) begin
      tick();
      pulses += pronto_config + erro_config;
    end
    chk("cancel pulses", pulses, 0);
    chk("cancel intervalo", intervalo, model_int);

    // Synchronous reset mid-frame.
    start();
    send(8'hA5);
    send(8'h00);
    reset = 1'b1;
    tick();
    chk("midrst state", db_estado, 0);
    chk("midrst intervalo", intervalo, 60);
    chk("midrst ocupado", ocupado, 0);
    reset = 1'b0;
    model_int = 16'd60;
    tick();

    for (int f = 0; f < 30; f++) begin
      case ($urandom_range(0, 3))
        0:       v = 16'($urandom_range(0, 4));
        1:       v = 16'($urandom_range(3595, 3605));
        2:       v = 16'($urandom_range(0, 65535));
        default: v = 16'($urandom_range(5, 3000));
      endcase
      m = v[15:8];
      l = v[7:0];
      c = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : (8'hA5 ^ m ^ l);
      start();
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        nb = 8'($urandom_range(0, 255));
        if (nb == 8'hA5) nb = 8'h3C;
        send(nb);
        idle($urandom_range(0, 3));
      end
      send(8'hA5);
      idle($urandom_range(0, 3));
      send(m);
      idle($urandom_range(0, 3));
      send(l);
      idle($urandom_range(0, 3));
      send(c);
      ok = ref_ok(m, l, c);
      if (ok) model_int = v;
      finish_frame($sformatf("rnd%0d", f), ok, model_int);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
